pc_fetch_sequencer: RTL and testbench

Owns the architectural program counter and sequences instruction fetch for the single-cycle core. Issues a request/acknowledge fetch to instruction memory and holds the instruction for the execute cycle. Applies the next-PC rule (sequential, conditional branch, unconditional branch) at retirement. Adds start, halt, stall and fetch-timeout fault handling around the existing next-PC datapath.

---
 rtl/pc_fetch_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and fetch/execute sequencer for the single-cycle core.
// Fetches with a req/ack handshake, holds the instruction for EXEC and applies next-PC at retirement.
module pc_fetch_sequencer #(
  parameter logic [63:0] RESET_PC      = 64'h0,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        Start,
  input  logic        Halt,
  input  logic        Stall,
  output logic        ImemReq,
  output logic [63:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  input  logic        Branch,
  input  logic        ALUZero,
  input  logic        Uncondbranch,
  input  logic [63:0] SignExtImm64,
  output logic [63:0] CurrentPC,
  output logic [31:0] InstrCount,
  output logic        Halted,
  output logic        Fault
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] FETCH  = 2'b01;
  localparam logic [1:0] EXEC   = 2'b10;
  localparam logic [1:0] HALTED = 2'b11;

  localparam int CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(FETCH_TIMEOUT - 1);

  logic [1:0]    state_r, state_next_s;
  logic [63:0]   pc_r, pc_next_s;
  logic [31:0]   instr_r, instr_next_s;
  logic [31:0]   count_r, count_next_s;
  logic [CW-1:0] wait_r, wait_next_s;
  logic          fault_r, fault_next_s;
  logic          imem_req_r, instr_valid_r, halted_r;
  logic          taken_s;
  logic [63:0]   target_pc_s;

  // Next-PC rule: the immediate is already a byte offset, so no shift is applied.
  always_comb begin
    taken_s = Uncondbranch | (Branch & ALUZero);
    if (taken_s) begin
      target_pc_s = pc_r + SignExtImm64;
    end else begin
      target_pc_s = pc_r + 64'd4;
    end
  end

  // Sequencer next-state and datapath-register update selection.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    instr_next_s = instr_r;
    count_next_s = count_r;
    wait_next_s  = wait_r;
    fault_next_s = fault_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          state_next_s = FETCH;
          wait_next_s  = '0;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        // An ack arriving on the limit cycle wins over the timeout.
        if (ImemAck) begin
          instr_next_s = ImemData;
          wait_next_s  = '0;
          state_next_s = EXEC;
        end else if (wait_r == WAIT_LIMIT) begin
          fault_next_s = 1'b1;
          state_next_s = HALTED;
        end else begin
          wait_next_s  = wait_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      EXEC: begin
        if (Stall) begin
          state_next_s = EXEC;
        end else if (Halt) begin
          state_next_s = HALTED;
        end else begin
          pc_next_s    = target_pc_s;
          count_next_s = count_r + 32'd1;
          state_next_s = FETCH;
        end
      end
      HALTED: begin
        state_next_s = HALTED;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, datapath registers and state-decoded outputs, all registered.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      instr_r       <= 32'h0;
      count_r       <= 32'h0;
      wait_r        <= '0;
      fault_r       <= 1'b0;
      imem_req_r    <= 1'b0;
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      pc_r          <= pc_next_s;
      instr_r       <= instr_next_s;
      count_r       <= count_next_s;
      wait_r        <= wait_next_s;
      fault_r       <= fault_next_s;
      imem_req_r    <= (state_next_s == FETCH);
      instr_valid_r <= (state_next_s == EXEC);
      halted_r      <= (state_next_s == HALTED);
    end
  end

  assign ImemReq     = imem_req_r;
  assign ImemAddr    = pc_r;
  assign CurrentPC   = pc_r;
  assign Instruction = instr_r;
  assign InstrValid  = instr_valid_r;
  assign InstrCount  = count_r;
  assign Halted      = halted_r;
  assign Fault       = fault_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: sequential flow, branches, stall/halt, timeout, async reset.
module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        Start, Halt, Stall;
  logic        ImemReq;
  logic [63:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        Branch, ALUZero, Uncondbranch;
  logic [63:0] SignExtImm64;
  logic [63:0] CurrentPC;
  logic [31:0] InstrCount;
  logic        Halted, Fault;

  int checks   = 0;
  int failures = 0;

  pc_fetch_sequencer #(.RESET_PC(64'h0), .FETCH_TIMEOUT(16)) dut (
    .CLK(CLK), .resetl(resetl), .Start(Start), .Halt(Halt), .Stall(Stall),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
    .Instruction(Instruction), .InstrValid(InstrValid), .Branch(Branch),
    .ALUZero(ALUZero), .Uncondbranch(Uncondbranch), .SignExtImm64(SignExtImm64),
    .CurrentPC(CurrentPC), .InstrCount(InstrCount), .Halted(Halted), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset;
    resetl = 1'b0; Start = 1'b0; Halt = 1'b0; Stall = 1'b0; ImemAck = 1'b0;
    ImemData = 32'h0; Branch = 1'b0; ALUZero = 1'b0; Uncondbranch = 1'b0;
    SignExtImm64 = 64'h0;
    repeat (2) @(posedge CLK);
    #1 resetl = 1'b1;
  endtask

  task automatic start_core;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic fetch_ack(input logic [31:0] data);
    ImemAck = 1'b1; ImemData = data;
    tick();
    ImemAck = 1'b0; ImemData = 32'h0;
  endtask

  task automatic exec_retire(input logic b, input logic z, input logic u, input logic [63:0] imm);
    Branch = b; ALUZero = z; Uncondbranch = u; SignExtImm64 = imm;
    tick();
    Branch = 1'b0; ALUZero = 1'b0; Uncondbranch = 1'b0; SignExtImm64 = 64'h0;
  endtask

  task automatic goto_pc4;
    apply_reset();
    start_core();
    fetch_ack(32'h0000_0001);
    exec_retire(1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if ({ImemReq, InstrValid, Halted, Fault} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {ImemReq, InstrValid, Halted, Fault});
    end
    checks++;
    if (CurrentPC !== 64'h0 || InstrCount !== 32'h0 || Instruction !== 32'h0) begin
      failures++; $display("FAIL reset_regs pc=%h cnt=%h ins=%h exp all zero", CurrentPC, InstrCount, Instruction);
    end
    Halt = 1'b1; Stall = 1'b1; ImemAck = 1'b1;
    tick();
    Halt = 1'b0; Stall = 1'b0; ImemAck = 1'b0;
    checks++;
    if (ImemReq !== 1'b0 || Halted !== 1'b0) begin
      failures++; $display("FAIL idle_ignores req=%b halted=%b exp 0 0", ImemReq, Halted);
    end
  endtask

  task automatic test_sequential;
    apply_reset();
    start_core();
    checks++;
    if (ImemReq !== 1'b1 || ImemAddr !== 64'h0) begin
      failures++; $display("FAIL seq_fetch0 req=%b addr=%h exp 1 0", ImemReq, ImemAddr);
    end
    fetch_ack(32'hDEADBEEF);
    checks++;
    if (InstrValid !== 1'b1 || Instruction !== 32'hDEADBEEF || ImemReq !== 1'b0) begin
      failures++; $display("FAIL seq_exec0 valid=%b ins=%h req=%b exp 1 deadbeef 0", InstrValid, Instruction, ImemReq);
    end
    exec_retire(1'b0, 1'b0, 1'b0, 64'h0);
    checks++;
    if (ImemReq !== 1'b1 || ImemAddr !== 64'h4 || InstrCount !== 32'd1) begin
      failures++; $display("FAIL seq_fetch1 req=%b addr=%h cnt=%0d exp 1 4 1", ImemReq, ImemAddr, InstrCount);
    end
    fetch_ack(32'hDEADBEEF);
    exec_retire(1'b0, 1'b0, 1'b0, 64'h0);
    checks++;
    if (CurrentPC !== 64'h8 || InstrCount !== 32'd2) begin
      failures++; $display("FAIL seq_after4 pc=%h cnt=%0d exp 8 2", CurrentPC, InstrCount);
    end
  endtask

  task automatic test_cond_branch;
    goto_pc4();
    fetch_ack(32'h1111_1111);
    exec_retire(1'b1, 1'b1, 1'b0, 64'h32);
    checks++;
    if (ImemAddr !== 64'h36) begin
      failures++; $display("FAIL br_taken addr=%h exp 36", ImemAddr);
    end
    goto_pc4();
    fetch_ack(32'h2222_2222);
    exec_retire(1'b1, 1'b0, 1'b0, 64'h36);
    checks++;
    if (ImemAddr !== 64'h8) begin
      failures++; $display("FAIL br_not_taken addr=%h exp 8", ImemAddr);
    end
  endtask

  task automatic test_uncond_branch;
    goto_pc4();
    fetch_ack(32'h3333_3333);
    exec_retire(1'b1, 1'b0, 1'b1, 64'h36);
    checks++;
    if (CurrentPC !== 64'h3A) begin
      failures++; $display("FAIL ub_fwd pc=%h exp 3a", CurrentPC);
    end
    goto_pc4();
    fetch_ack(32'h4444_4444);
    exec_retire(1'b0, 1'b0, 1'b0, 64'h0);
    fetch_ack(32'h5555_5555);
    exec_retire(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    checks++;
    if (CurrentPC !== 64'h4 || InstrCount !== 32'd3) begin
      failures++; $display("FAIL ub_back pc=%h cnt=%0d exp 4 3", CurrentPC, InstrCount);
    end
  endtask

  task automatic test_stall_halt;
    goto_pc4();
    fetch_ack(32'h1234_5678);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Halt = (i == 1);
      tick();
      checks++;
      if (InstrValid !== 1'b1 || Halted !== 1'b0 || CurrentPC !== 64'h4 ||
          InstrCount !== 32'd1 || Instruction !== 32'h1234_5678) begin
        failures++;
        $display("FAIL stall_hold%0d valid=%b halted=%b pc=%h cnt=%0d ins=%h exp 1 0 4 1 12345678",
                 i, InstrValid, Halted, CurrentPC, InstrCount, Instruction);
      end
    end
    Stall = 1'b0; Halt = 1'b0;
    tick();
    checks++;
    if (CurrentPC !== 64'h8 || InstrCount !== 32'd2 || ImemReq !== 1'b1) begin
      failures++; $display("FAIL stall_release pc=%h cnt=%0d req=%b exp 8 2 1", CurrentPC, InstrCount, ImemReq);
    end
    fetch_ack(32'h9ABC_DEF0);
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    checks++;
    if (Halted !== 1'b1 || CurrentPC !== 64'h8 || InstrCount !== 32'd2 || InstrValid !== 1'b0 || Fault !== 1'b0) begin
      failures++;
      $display("FAIL halt pc=%h cnt=%0d halted=%b valid=%b fault=%b exp 8 2 1 0 0",
               CurrentPC, InstrCount, Halted, InstrValid, Fault);
    end
    Start = 1'b1; ImemAck = 1'b1;
    repeat (2) tick();
    Start = 1'b0; ImemAck = 1'b0;
    checks++;
    if (Halted !== 1'b1 || ImemReq !== 1'b0) begin
      failures++; $display("FAIL halt_terminal halted=%b req=%b exp 1 0", Halted, ImemReq);
    end
  endtask

  task automatic test_timeout;
    int early;
    apply_reset();
    start_core();
    early = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (Halted !== 1'b0 || ImemReq !== 1'b1 || Fault !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      failures++; $display("FAIL to_early bad_cycles=%0d exp 0", early);
    end
    tick();
    checks++;
    if (Halted !== 1'b1 || Fault !== 1'b1 || ImemReq !== 1'b0) begin
      failures++; $display("FAIL to_fault halted=%b fault=%b req=%b exp 1 1 0", Halted, Fault, ImemReq);
    end
    apply_reset();
    checks++;
    if (Fault !== 1'b0) begin
      failures++; $display("FAIL to_fault_clear fault=%b exp 0", Fault);
    end
    start_core();
    repeat (15) tick();
    fetch_ack(32'hCAFE_F00D);
    checks++;
    if (InstrValid !== 1'b1 || Fault !== 1'b0 || Halted !== 1'b0 || Instruction !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL to_ack_at_limit valid=%b fault=%b halted=%b ins=%h exp 1 0 0 cafef00d",
               InstrValid, Fault, Halted, Instruction);
    end
  endtask

  task automatic test_reset_mid_fetch;
    goto_pc4();
    resetl = 1'b0;
    #1;
    checks++;
    if (ImemReq !== 1'b0 || CurrentPC !== 64'h0 || InstrCount !== 32'd0 || InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_fetch req=%b pc=%h cnt=%0d valid=%b exp 0 0 0 0",
               ImemReq, CurrentPC, InstrCount, InstrValid);
    end
    tick();
    resetl = 1'b1;
    tick();
    checks++;
    if (ImemReq !== 1'b0 || Halted !== 1'b0) begin
      failures++; $display("FAIL reset_to_idle req=%b halted=%b exp 0 0", ImemReq, Halted);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_cond_branch();
    test_uncond_branch();
    test_stall_halt();
    test_timeout();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
